// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : ASCII constants, FSM state type and hex helpers for the command
//            responder.
// Revision : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

  localparam logic [7:0] CHAR_R = 8'h52;
  localparam logic [7:0] CHAR_W = 8'h57;
  localparam logic [7:0] CHAR_K = 8'h4B;
  localparam logic [7:0] CHAR_Q = 8'h3F;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] SP     = 8'h20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARG  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [7:0] hex_enc(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  // Returns {valid, nibble}; letters in either case map through their low nibble + 9.
  function automatic logic [4:0] hex_dec(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_resp_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_resp_serializer
// Brief    : Presents a loaded reply of 1..4 bytes on a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module uart_resp_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_len,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done
);

  logic [31:0] r_buf;
  logic [2:0]  r_len;
  logic [2:0]  r_idx;
  logic [7:0]  w_next_byte;

  // r_idx counts bytes already presented, so it also selects the next one.
  assign w_next_byte = r_buf[{r_idx[1:0], 3'b000} +: 8];
  assign done        = out_valid && out_ready && (r_idx == r_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf     <= 32'h0;
      r_len     <= 3'd0;
      r_idx     <= 3'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else if (load) begin
      r_buf     <= load_data;
      r_len     <= load_len;
      r_idx     <= 3'd1;
      out_data  <= load_data[7:0];
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      if (r_idx == r_len) begin
        out_valid <= 1'b0;
      end else begin
        out_data <= w_next_byte;
        r_idx    <= r_idx + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_responder
// Brief    : Parses ASCII R<aa>/W<aadd> commands against a byte register file
//            and replies in ASCII on the device-to-host stream.
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int         NUM_REGS       = 4,
  parameter logic [7:0] ID_VALUE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 48_000_000
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_REGS*8-1:0] regs
);

  localparam int              TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int              AW      = $clog2(NUM_REGS);
  localparam logic [TW-1:0]   C_TMO   = TW'(TIMEOUT_CYCLES);
  localparam logic [8:0]      C_NREGS = 9'(NUM_REGS);
  localparam logic [31:0]     C_Q_REPLY = {8'h00, LF, CR, CHAR_Q};
  localparam logic [31:0]     C_K_REPLY = {8'h00, LF, CR, CHAR_K};

  state_t        r_state;
  logic [15:0]   r_acc;
  logic [2:0]    r_nib;
  logic          r_is_wr;
  logic [TW-1:0] r_timer;

  logic          w_accept, w_tmo, w_idle_like, w_done;
  logic          w_is_r, w_is_w, w_is_ws;
  logic [4:0]    w_dec;
  logic [15:0]   w_acc_next;
  logic [7:0]    w_rd_val;
  logic          w_load, w_wr_en;
  logic [31:0]   w_load_data;
  logic [2:0]    w_load_len;
  logic [7:0]    w_file [NUM_REGS];

  assign in_ready    = !reset && (r_state != RESP);
  assign w_accept    = in_valid && in_ready;
  assign w_tmo       = (r_state == ARG) && (r_timer == C_TMO);
  // A byte landing on the timeout edge is parsed as a fresh command byte.
  assign w_idle_like = (r_state == IDLE) || w_tmo;
  assign w_is_r      = (in_data == CHAR_R) || (in_data == (CHAR_R | 8'h20));
  assign w_is_w      = (in_data == CHAR_W) || (in_data == (CHAR_W | 8'h20));
  assign w_is_ws     = (in_data == CR) || (in_data == LF) || (in_data == SP);
  assign w_dec       = hex_dec(in_data);
  assign w_acc_next  = {r_acc[11:0], w_dec[3:0]};
  assign w_rd_val    = w_file[w_acc_next[AW-1:0]];

  always_comb begin
    w_load      = 1'b0;
    w_load_data = 32'h0;
    w_load_len  = 3'd0;
    w_wr_en     = 1'b0;
    if (w_accept && w_idle_like) begin
      if (!(w_is_r || w_is_w || w_is_ws)) begin
        w_load = 1'b1; w_load_data = C_Q_REPLY; w_load_len = 3'd3;
      end
    end else if (w_accept && r_state == ARG) begin
      if (!w_dec[4]) begin
        w_load = 1'b1; w_load_data = C_Q_REPLY; w_load_len = 3'd3;
      end else if (r_nib == 3'd1) begin
        w_load = 1'b1; w_load_data = C_Q_REPLY; w_load_len = 3'd3;
        if (!r_is_wr) begin
          if ({1'b0, w_acc_next[7:0]} < C_NREGS) begin
            w_load_data = {LF, CR, hex_enc(w_rd_val[3:0]), hex_enc(w_rd_val[7:4])};
            w_load_len  = 3'd4;
          end
        end else if (w_acc_next[15:8] != 8'h00 && {1'b0, w_acc_next[15:8]} < C_NREGS) begin
          w_wr_en     = 1'b1;
          w_load_data = C_K_REPLY;
        end
      end
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= 16'h0;
      r_nib   <= 3'd0;
      r_is_wr <= 1'b0;
      r_timer <= '0;
    end else begin
      if (r_state == ARG && !w_accept && !w_tmo)
        r_timer <= r_timer + 1'b1;
      else
        r_timer <= '0;

      if (w_load) begin
        r_state <= RESP;
      end else if (r_state == RESP) begin
        if (w_done) r_state <= IDLE;
      end else if (w_accept && w_idle_like) begin
        r_acc <= 16'h0;
        if (w_is_r || w_is_w) begin
          r_state <= ARG;
          r_nib   <= w_is_w ? 3'd4 : 3'd2;
          r_is_wr <= w_is_w;
        end else begin
          r_state <= IDLE;
        end
      end else if (w_accept) begin
        r_acc <= w_acc_next;
        r_nib <= r_nib - 3'd1;
      end else if (w_tmo) begin
        r_state <= IDLE;
      end
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs
    if (n == 0) begin : g_id
      assign w_file[n] = ID_VALUE;
    end else begin : g_rw
      logic [7:0] r_val;
      always_ff @(posedge clk_48mhz) begin
        if (reset)
          r_val <= 8'h00;
        else if (w_wr_en && w_acc_next[15:8] == 8'(n))
          r_val <= w_acc_next[7:0];
      end
      assign w_file[n] = r_val;
    end
    assign regs[8*n +: 8] = w_file[n];
  end

  uart_resp_serializer u_ser (
    .clk       (clk_48mhz),
    .rst       (reset),
    .load      (w_load),
    .load_data (w_load_data),
    .load_len  (w_load_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (w_done)
  );

endmodule
`default_nettype wire
